// File: rtl/rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pkg
//  Description : Shared types and constants for the round-robin slot link.
//                Slot order is a->b->c->d, one slot per clock.
//  Revision    : 1.0  initial release
// ============================================================================
package rr_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);

  // Named slots; bit k of a frame carries slot k.
  typedef enum logic [SLOT_W-1:0] {
    SLOT_A = 2'd0,
    SLOT_B = 2'd1,
    SLOT_C = 2'd2,
    SLOT_D = 2'd3
  } slot_e;

  // Receiver FSM state encoding.
  typedef logic [0:0] state_t;
  localparam state_t ST_ALIGN   = 1'b0;
  localparam state_t ST_COLLECT = 1'b1;

  typedef logic [NUM_SLOTS-1:0] frame_t;

endpackage
`default_nettype wire

// File: rtl/rr_frame_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_frame_outreg
//  Description : One-entry valid/ready output register. A frame arriving
//                while the held frame is still unconsumed is dropped and a
//                sticky overrun flag is raised. An accept on the same edge as
//                a new arrival makes room, so that case is a clean reload.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_frame_outreg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  input  logic         clr_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         overrun_o
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         ovr_q, ovr_d;
  logic         accept_w;
  logic         drop_w;

  // Next-state for the holding register; ready only reaches the flops.
  always_comb begin
    accept_w = valid_q & ready_i;
    drop_w   = load_i & valid_q & ~ready_i;
    data_d   = data_q;
    valid_d  = valid_q;
    if (load_i && !drop_w) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (accept_w) begin
      valid_d = 1'b0;
    end
    // A drop on the same edge as a clear keeps the flag set.
    if (drop_w) begin
      ovr_d = 1'b1;
    end else if (clr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // Output register state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;

endmodule
`default_nettype wire

// File: rtl/rr_slot_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : rr_slot_deserializer
//  Description : Receive side of the 4-way round-robin slot link. Discards the
//                serializer pipeline latency after reset, then collects one
//                bit per slot into a frame and hands complete frames to a
//                valid/ready output register. Collection never stalls.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_slot_deserializer #(
  parameter int NUM_SLOTS = 4,
  parameter int LATENCY   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ser_in_i,
  output logic [NUM_SLOTS-1:0]         frame_data_o,
  output logic                         frame_valid_o,
  input  logic                         frame_ready_i,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_idx_o,
  output logic                         overrun_o,
  input  logic                         overrun_clr_i
);

  import rr_pkg::*;

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(LATENCY);
  localparam logic [IDX_W-1:0] LAST_C   = IDX_W'(NUM_SLOTS - 1);
  // With no pipeline latency the very first sample is already slot 0.
  localparam state_t           ST_RESET = (LATENCY == 0) ? ST_COLLECT : ST_ALIGN;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     slot_q, slot_d;
  logic [NUM_SLOTS-1:0] asm_q, asm_d;
  logic [NUM_SLOTS-1:0] word_w;
  logic                 done_w;

  // Alignment countdown, slot counter and frame assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    asm_d   = asm_q;
    done_w  = 1'b0;
    word_w  = asm_q;
    word_w[slot_q] = ser_in_i;
    case (state_q)
      ST_ALIGN: begin
        slot_d = '0;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_COLLECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_COLLECT: begin
        asm_d  = word_w;
        slot_d = slot_q + IDX_W'(1);
        done_w = (slot_q == LAST_C);
      end
      default: state_d = ST_ALIGN;
    endcase
  end

  // FSM, counter and assembly registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RESET;
      cnt_q   <= LAT_C;
      slot_q  <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      asm_q   <= asm_d;
    end
  end

  rr_frame_outreg #(
    .W (NUM_SLOTS)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (done_w),
    .data_i    (word_w),
    .ready_i   (frame_ready_i),
    .clr_i     (overrun_clr_i),
    .data_o    (frame_data_o),
    .valid_o   (frame_valid_o),
    .overrun_o (overrun_o)
  );

  assign slot_idx_o = slot_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_slot_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_slot_deserializer
//  Description : Scoreboard bench for rr_slot_deserializer (LATENCY=1 and
//                LATENCY=0 instances).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_slot_deserializer;

  logic       clk = 1'b0;
  logic       rst, ser, rdy, clr;
  logic [3:0] fd;
  logic       fv, ov;
  logic [1:0] si;

  logic       rst0, ser0, rdy0, clr0;
  logic [3:0] fd0;
  logic       fv0, ov0;
  logic [1:0] si0;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] sb[$];

  logic       v1, o1;
  logic [3:0] d1;

  always #5 clk = ~clk;

  rr_slot_deserializer #(.NUM_SLOTS(4), .LATENCY(1)) dut (
    .clk (clk), .rst (rst), .ser_in_i (ser),
    .frame_data_o (fd), .frame_valid_o (fv), .frame_ready_i (rdy),
    .slot_idx_o (si), .overrun_o (ov), .overrun_clr_i (clr)
  );

  rr_slot_deserializer #(.NUM_SLOTS(4), .LATENCY(0)) dut0 (
    .clk (clk), .rst (rst0), .ser_in_i (ser0),
    .frame_data_o (fd0), .frame_valid_o (fv0), .frame_ready_i (rdy0),
    .slot_idx_o (si0), .overrun_o (ov0), .overrun_clr_i (clr0)
  );

  // Single comparison point.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; pop the scoreboard when a handshake will occur on this edge.
  task automatic cyc(input logic s, input logic r, input logic c);
    ser = s; rdy = r; clr = c;
    if (fv && r) begin
      if (sb.size() == 0) check_eq("sb_empty_pop", sb.size(), 1);
      else                check_eq("sb_frame", {28'd0, fd}, {28'd0, sb.pop_front()});
    end
    @(posedge clk); #1;
  endtask

  // One full frame, slot 0 first; snapshot outputs after its first cycle.
  task automatic send_frame(input logic [3:0] bits, input logic [3:0] rmask,
                            input logic [3:0] cmask, input bit push,
                            output logic v, output logic o, output logic [3:0] d);
    if (push) sb.push_back(bits);
    v = 1'b0; o = 1'b0; d = 4'd0;
    for (int i = 0; i < 4; i++) begin
      check_eq("slot_idx", {30'd0, si}, i);
      cyc(bits[i], rmask[i], cmask[i]);
      if (i == 0) begin v = fv; o = ov; d = fd; end
    end
  endtask

  initial begin
    rst = 1'b0; ser = 1'b0; rdy = 1'b0; clr = 1'b0;
    rst0 = 1'b0; ser0 = 1'b0; rdy0 = 1'b1; clr0 = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    check_eq("rst_data",  {28'd0, fd}, 0);
    check_eq("rst_valid", {31'd0, fv}, 0);
    check_eq("rst_ovr",   {31'd0, ov}, 0);
    check_eq("rst_slot",  {30'd0, si}, 0);

    // Release; first sample is discarded (drive 1 to prove it is ignored).
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    send_frame(4'b0001, 4'b0000, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("f1_valid", {31'd0, fv}, 1);
    check_eq("f1_data",  {28'd0, fd}, 4'b0001);

    // Streamed frames 1011 and 0110 (slot 0 first) with ready high.
    send_frame(4'b1101, 4'b1111, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("accept_clears_valid", {31'd0, v1}, 0);
    check_eq("f2_data", {28'd0, fd}, 4'b1101);
    send_frame(4'b0110, 4'b1111, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("f3_data",  {28'd0, fd}, 4'b0110);
    check_eq("f3_ovr",   {31'd0, ov}, 0);

    // Back-pressure: 0001 held, 1111 dropped.
    send_frame(4'b0001, 4'b0001, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("f4_data", {28'd0, fd}, 4'b0001);
    check_eq("f4_ovr",  {31'd0, ov}, 0);
    send_frame(4'b1111, 4'b0000, 4'b0000, 1'b0, v1, o1, d1);
    check_eq("drop_ovr",   {31'd0, ov}, 1);
    check_eq("drop_hold",  {28'd0, fd}, 4'b0001);
    check_eq("drop_valid", {31'd0, fv}, 1);

    // Clear overrun, then accept on the completion edge of the next frame.
    send_frame(4'b1010, 4'b1000, 4'b0001, 1'b1, v1, o1, d1);
    check_eq("clr_ovr",  {31'd0, o1}, 0);
    check_eq("clr_hold", {28'd0, d1}, 4'b0001);
    check_eq("swap_valid", {31'd0, fv}, 1);
    check_eq("swap_data",  {28'd0, fd}, 4'b1010);
    check_eq("swap_ovr",   {31'd0, ov}, 0);

    send_frame(4'b1001, 4'b1111, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("f7_data", {28'd0, fd}, 4'b1001);

    // Reset at slot 2 with a pending frame.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("pre_rst_slot", {30'd0, si}, 2);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check_eq("midrst_valid", {31'd0, fv}, 0);
    check_eq("midrst_data",  {28'd0, fd}, 0);
    check_eq("midrst_slot",  {30'd0, si}, 0);
    sb.delete();
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    send_frame(4'b1110, 4'b0000, 4'b0000, 1'b1, v1, o1, d1);
    check_eq("post_rst_data", {28'd0, fd}, 4'b1110);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("post_rst_valid", {31'd0, fv}, 0);
    check_eq("sb_drained", sb.size(), 0);

    // LATENCY=0 instance: first sample after release is slot 0.
    rst = 1'b0;
    rst0 = 1'b1;
    check_eq("l0_slot0", {30'd0, si0}, 0);
    ser0 = 1'b1; cyc(1'b0, 1'b0, 1'b0);
    check_eq("l0_slot1", {30'd0, si0}, 1);
    ser0 = 1'b1; cyc(1'b0, 1'b0, 1'b0);
    ser0 = 1'b0; cyc(1'b0, 1'b0, 1'b0);
    ser0 = 1'b0; cyc(1'b0, 1'b0, 1'b0);
    check_eq("l0_valid", {31'd0, fv0}, 1);
    check_eq("l0_data",  {28'd0, fd0}, 4'b0011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
